// File: rtl/aes256_keysched_ctrl.sv
// AES-256 key schedule controller: loads an 8-word key, expands it one word per cycle
// through an external S-box port, and serves 128-bit round keys. Optional: KEYSCHED_ZEROIZE_EN.
module aes256_keysched_ctrl #(
    parameter int NK = 8,
    parameter int NR = 14,
    parameter int NB = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_word,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic         rk_err,
    output logic [127:0] rk_data,
    output logic         busy,
    output logic         keys_ready
);
    localparam int NW = NB * (NR + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_READY  = 2'd3;

    localparam logic [5:0] I_FIRST = 6'(NK);
    localparam logic [5:0] I_LAST  = 6'(NW - 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        rot_word = {x[23:0], x[31:24]};
    endfunction

    logic [31:0]  w_r [0:NW-1];
    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic [2:0]   cnt_r;
    logic [5:0]   i_r;
    logic [7:0]   rcon_r;
    logic         key_ready_r;
    logic         busy_r;
    logic         keys_ready_r;
    logic         rk_valid_r;
    logic         rk_err_r;
    logic [31:0]  sb_in_r;
    logic [127:0] rk_data_r;

    logic         accept_s;
    logic         last_load_s;
    logic         last_exp_s;
    logic         rk_take_s;
    logic         rk_ok_s;
    logic [5:0]   rk_base_s;
    logic [31:0]  prev_s;
    logic [31:0]  back_s;
    logic [31:0]  new_word_s;
    logic         wr_en_s;
    logic [5:0]   wr_addr_s;
    logic [31:0]  wr_data_s;

    assign accept_s    = key_valid && key_ready_r;
    assign last_load_s = (cnt_r == 3'(NK - 1));
    assign last_exp_s  = (i_r == I_LAST);
    assign rk_take_s   = rk_req && (state_r == S_READY);
    assign rk_ok_s     = (rk_idx <= 4'(NR));
    assign rk_base_s   = {rk_idx, 2'b00};

    // Next-state decode of the load/expand sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_LOAD;
                else          state_nxt_s = S_IDLE;
            end
            S_LOAD: begin
                if (accept_s && last_load_s) state_nxt_s = S_EXPAND;
                else                         state_nxt_s = S_LOAD;
            end
            S_EXPAND: begin
                if (last_exp_s) state_nxt_s = S_READY;
                else            state_nxt_s = S_EXPAND;
            end
            S_READY: begin
                if (accept_s) state_nxt_s = S_LOAD;
                else          state_nxt_s = S_READY;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Expansion word w[i]; sb_in was prepared one cycle earlier for this i
    always_comb begin
        new_word_s = 32'h0000_0000;
        prev_s     = w_r[i_r - 6'd1];
        back_s     = w_r[i_r - 6'd8];
        case (i_r[2:0])
            3'd0:    new_word_s = back_s ^ sb_out ^ {rcon_r, 24'h00_0000};
            3'd4:    new_word_s = back_s ^ sb_out;
            default: new_word_s = back_s ^ prev_s;
        endcase
    end

    // Single write port into the word array
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 6'd0;
        wr_data_s = 32'h0000_0000;
        if (accept_s && ((state_r == S_IDLE) || (state_r == S_READY))) begin
            wr_en_s   = 1'b1;
            wr_addr_s = 6'd0;
            wr_data_s = key_word;
        end else if (accept_s && (state_r == S_LOAD)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = {3'b000, cnt_r};
            wr_data_s = key_word;
        end else if (state_r == S_EXPAND) begin
            wr_en_s   = 1'b1;
            wr_addr_s = i_r;
            wr_data_s = new_word_s;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = 6'd0;
            wr_data_s = 32'h0000_0000;
        end
    end

    // Sequencer state, counters, status outputs and the registered S-box operand
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= 3'd0;
            i_r          <= 6'd0;
            rcon_r       <= 8'h01;
            key_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            keys_ready_r <= 1'b0;
            sb_in_r      <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            key_ready_r  <= (state_nxt_s != S_EXPAND);
            busy_r       <= (state_nxt_s == S_LOAD) || (state_nxt_s == S_EXPAND);
            keys_ready_r <= (state_nxt_s == S_READY);
            case (state_r)
                S_IDLE, S_READY: begin
                    if (accept_s) cnt_r <= 3'd1;
                    else          cnt_r <= cnt_r;
                end
                S_LOAD: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + 3'd1;
                        if (last_load_s) begin
                            i_r     <= I_FIRST;
                            rcon_r  <= 8'h01;
                            sb_in_r <= rot_word(key_word);
                        end else begin
                            i_r <= i_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_EXPAND: begin
                    if (i_r[2:0] == 3'd0) rcon_r <= xtime(rcon_r);
                    else                  rcon_r <= rcon_r;
                    if (last_exp_s) begin
                        i_r     <= 6'd0;
                        sb_in_r <= 32'h0000_0000;
                    end else begin
                        i_r     <= i_r + 6'd1;
                        sb_in_r <= (i_r[2:0] == 3'd7) ? rot_word(new_word_s) : new_word_s;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Round-key word storage
    always_ff @(posedge clk) begin
`ifdef KEYSCHED_ZEROIZE_EN
        if (reset) begin
            for (int k = 0; k < NW; k++) w_r[k] <= 32'h0000_0000;
        end else begin
            if (accept_s && (state_r == S_READY)) begin
                for (int k = NK; k < NW; k++) w_r[k] <= 32'h0000_0000;
            end
            if (wr_en_s) w_r[wr_addr_s] <= wr_data_s;
        end
`else
        if (!reset && wr_en_s) w_r[wr_addr_s] <= wr_data_s;
`endif
    end

    // Round-key read port; reads the array before any same-cycle reload write lands
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_valid_r <= 1'b0;
            rk_err_r   <= 1'b0;
            rk_data_r  <= 128'h0;
        end else begin
            rk_valid_r <= rk_take_s && rk_ok_s;
            rk_err_r   <= rk_take_s && !rk_ok_s;
            if (rk_take_s && rk_ok_s) begin
                rk_data_r <= {w_r[rk_base_s], w_r[rk_base_s + 6'd1],
                              w_r[rk_base_s + 6'd2], w_r[rk_base_s + 6'd3]};
            end else begin
`ifdef KEYSCHED_ZEROIZE_EN
                rk_data_r <= 128'h0;
`else
                rk_data_r <= rk_data_r;
`endif
            end
        end
    end

    assign key_ready  = key_ready_r;
    assign busy       = busy_r;
    assign keys_ready = keys_ready_r;
    assign sb_in      = sb_in_r;
    assign rk_valid   = rk_valid_r;
    assign rk_err     = rk_err_r;
    assign rk_data    = rk_data_r;

endmodule

// File: tb/tb_aes256_keysched_ctrl.sv
// Self-checking bench for aes256_keysched_ctrl: FIPS-197 AES-256 vectors plus random keys
// checked against a loop-based key-expansion model with an arithmetically derived S-box.
module tb_aes256_keysched_ctrl;
    logic         clk;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [31:0]  key_word;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_err;
    logic [127:0] rk_data;
    logic         busy;
    logic         keys_ready;

    int           n_checks;
    int           n_fail;
    logic [7:0]   sbox [256];
    logic [31:0]  cur_key [8];
    logic [31:0]  ref_w [60];
    logic [127:0] last_data;

    aes256_keysched_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_word   (key_word),
        .sb_in      (sb_in),
        .sb_out     (sb_out),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_err     (rk_err),
        .rk_data    (rk_data),
        .busy       (busy),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sb_out = {sbox[sb_in[31:24]], sbox[sb_in[23:16]], sbox[sb_in[15:8]], sbox[sb_in[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    function automatic logic [127:0] held_data();
`ifdef KEYSCHED_ZEROIZE_EN
        return 128'h0;
`else
        return last_data;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic build_model();
        logic [31:0] t;
        int rc;
        rc = 1;
        for (int i = 0; i < 8; i++) ref_w[i] = cur_key[i];
        for (int i = 8; i < 60; i++) begin
            t = ref_w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {8'(rc), 24'h0};
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-8] ^ t;
        end
    endtask

    task automatic send_first();
        logic kr;
        key_valid = 1'b1;
        key_word  = cur_key[0];
        kr = key_ready;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("first_accept", 128'(kr), 128'd1);
        check("busy_load", 128'(busy), 128'd1);
    endtask

    task automatic load_rest(input bit gaps);
        int j, guard;
        logic v, kr;
        j = 1; guard = 0;
        while (j < 8 && guard < 100) begin
            v = gaps ? ((guard % 2) == 0) : 1'b1;
            key_valid = v;
            key_word  = cur_key[j];
            rk_req    = 1'($urandom_range(0, 1));
            rk_idx    = 4'($urandom_range(0, 15));
            kr = key_ready;
            @(posedge clk); #1;
            if (v && kr) j++;
            check("rk_ignored_load", 128'(rk_valid | rk_err), 128'd0);
            guard++;
        end
        key_valid = 1'b0;
        rk_req    = 1'b0;
        check("load_done", 128'(j), 128'd8);
        check("sb_in_first", 128'(sb_in), 128'({cur_key[7][23:0], cur_key[7][31:24]}));
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 1;
        while (!keys_ready && cyc < 200) begin
            check("key_ready_expand", 128'(key_ready), 128'd0);
            check("busy_expand", 128'(busy), 128'd1);
            rk_req = 1'($urandom_range(0, 1));
            rk_idx = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            cyc++;
            check("rk_ignored_expand", 128'(rk_valid | rk_err), 128'd0);
        end
        rk_req = 1'b0;
        // cycle 0 is the 8th accept; keys_ready must be seen first in cycle 53
        check("keys_ready_latency", 128'(cyc), 128'd53);
        check("busy_ready", 128'(busy), 128'd0);
        check("key_ready_ready", 128'(key_ready), 128'd1);
    endtask

    task automatic expect_resp(input int idx);
        if (idx <= 14) begin
            check("rk_valid", 128'(rk_valid), 128'd1);
            check("rk_err_clear", 128'(rk_err), 128'd0);
            check("rk_data", rk_data, ref_rk(idx));
            last_data = ref_rk(idx);
        end else begin
            check("rk_valid_bad", 128'(rk_valid), 128'd0);
            check("rk_err", 128'(rk_err), 128'd1);
            check("rk_data_bad", rk_data, held_data());
        end
    endtask

    task automatic pulse_check();
        @(posedge clk); #1;
        check("rk_pulse", 128'(rk_valid | rk_err), 128'd0);
        check("rk_hold", rk_data, held_data());
    endtask

    task automatic read_one(input int idx);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        @(posedge clk); #1;
        rk_req = 1'b0;
        expect_resp(idx);
    endtask

    task automatic read_burst(input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = $urandom_range(0, 15);
            rk_req = 1'b1;
            rk_idx = 4'(idx);
            @(posedge clk); #1;
            expect_resp(idx);
        end
        rk_req = 1'b0;
        pulse_check();
    endtask

    initial begin
        int idx;
        logic [127:0] exp_old;
        n_checks = 0; n_fail = 0;
        last_data = 128'h0;
        build_sbox();
        reset = 1'b1; key_valid = 1'b0; key_word = 32'h0; rk_req = 1'b0; rk_idx = 4'd0;
        repeat (2) @(posedge clk); #1;
        check("rst_key_ready", 128'(key_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_keys_ready", 128'(keys_ready), 128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_err", 128'(rk_err), 128'd0);
        check("rst_rk_data", rk_data, 128'h0);
        check("rst_sb_in", 128'(sb_in), 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_key_ready", 128'(key_ready), 128'd1);

        // FIPS-197 AES-256 key at full rate
        for (int j = 0; j < 8; j++) cur_key[j] = 32'h0001_0203 + 32'(j) * 32'h0404_0404;
        build_model();
        send_first();
        load_rest(1'b0);
        wait_ready();
        read_one(0);
        check("fips_rk0", rk_data, 128'h000102030405060708090a0b0c0d0e0f);
        read_one(1);
        check("fips_rk1", rk_data, 128'h101112131415161718191a1b1c1d1e1f);
        read_one(2);
        check("fips_rk2", rk_data, 128'ha573c29fa176c498a97fce93a572c09c);
        read_one(14);
        check("fips_rk14", rk_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        pulse_check();
        read_one(15);
        pulse_check();
        read_burst(16);

        // same key reloaded with key_valid toggling
        send_first();
        load_rest(1'b1);
        wait_ready();
        read_one(14);
        check("gap_rk14", rk_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // reload a random key while requesting a round key in the same cycle
        idx = $urandom_range(0, 14);
        exp_old = ref_rk(idx);
        for (int j = 0; j < 8; j++) cur_key[j] = $urandom;
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        send_first();
        rk_req = 1'b0;
        check("reload_rk_valid", 128'(rk_valid), 128'd1);
        check("reload_old_key", rk_data, exp_old);
        check("reload_keys_ready_drop", 128'(keys_ready), 128'd0);
        last_data = exp_old;
        build_model();
        load_rest(1'b1);
        wait_ready();
        read_burst(12);

        // reset in the middle of expansion (i=30), then a fresh key
        for (int j = 0; j < 8; j++) cur_key[j] = $urandom;
        send_first();
        load_rest(1'b0);
        repeat (22) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_keys_ready", 128'(keys_ready), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_key_ready", 128'(key_ready), 128'd0);
        check("mid_rst_sb_in", 128'(sb_in), 128'd0);
        check("mid_rst_rk_data", rk_data, 128'h0);
        last_data = 128'h0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_idle", 128'(key_ready), 128'd1);
        for (int j = 0; j < 8; j++) cur_key[j] = $urandom;
        build_model();
        send_first();
        load_rest(1'b0);
        wait_ready();
        read_one(2);
        for (int r = 0; r < 16; r++) read_one(r);
        pulse_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
